// File: rtl/double_pulse_monitor_pkg.sv
// Shared types and constants for the double-pulse gate-drive feedback checker.
package double_pulse_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_P1_HIGH,
        S_GAP_LOW,
        S_P2_HIGH,
        S_QUIET
    } state_e;

    localparam int T_HIGH_CYC = 800;
    localparam int T_GAP_CYC  = 520;

    localparam int ERR_W       = 5;
    localparam int ERR_W1      = 0;
    localparam int ERR_GAP     = 1;
    localparam int ERR_W2      = 2;
    localparam int ERR_TIMEOUT = 3;
    localparam int ERR_EXTRA   = 4;

endpackage

// File: rtl/double_pulse_monitor_pulse_sync_edge.sv
// 2-FF synchroniser for an asynchronous level, followed by registered rise/fall strobes.
module pulse_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);

    logic       r_s1;
    logic       r_s2;
    logic       r_s3;
    logic [2:0] r_vld;
    logic       r_rise;
    logic       r_fall;

    // Strobes stay quiet until the pipeline holds real samples, so a line
    // already high when reset releases is not seen as a rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_s3   <= 1'b0;
            r_vld  <= '0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_s1   <= i_async;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_vld  <= {r_vld[1:0], 1'b1};
            r_rise <= r_vld[2] &  r_s2 & ~r_s3;
            r_fall <= r_vld[2] & ~r_s2 &  r_s3;
        end
    end

    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/double_pulse_monitor.sv
// Measures high width, low gap and second high width of a returned double pulse
// and reports widths, tolerance errors and pass once per burst.
module double_pulse_monitor #(
    parameter int CNT_W       = 16,
    parameter int T_HIGH_CYC  = double_pulse_pkg::T_HIGH_CYC,
    parameter int T_GAP_CYC   = double_pulse_pkg::T_GAP_CYC,
    parameter int TOL_CYC     = 8,
    parameter int QUIET_CYC   = 2000,
    parameter int TIMEOUT_CYC = 4000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] w1,
    output logic [CNT_W-1:0] gap,
    output logic [CNT_W-1:0] w2,
    output logic [4:0]       err_flags
);

    import double_pulse_pkg::*;

    localparam logic signed [CNT_W:0] NOM_HIGH_S = (CNT_W+1)'(T_HIGH_CYC);
    localparam logic signed [CNT_W:0] NOM_GAP_S  = (CNT_W+1)'(T_GAP_CYC);
    localparam logic signed [CNT_W:0] TOL_S      = (CNT_W+1)'(TOL_CYC);
    localparam logic [CNT_W-1:0]      QUIET_LIM  = CNT_W'(QUIET_CYC);
    localparam logic [CNT_W-1:0]      TMO_LIM    = CNT_W'(TIMEOUT_CYC);

    logic             w_rise;
    logic             w_fall;
    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_w1m;
    logic [CNT_W-1:0] r_gapm;
    logic [CNT_W-1:0] r_w2m;
    logic             w_start;
    logic             w_lat_w1;
    logic             w_lat_gap;
    logic             w_lat_w2;
    logic             w_done_nxt;
    logic             w_timeout;
    logic             w_extra;
    logic [ERR_W-1:0] w_err;
    logic             r_done;
    logic             r_pass;
    logic [CNT_W-1:0] r_w1;
    logic [CNT_W-1:0] r_gap;
    logic [CNT_W-1:0] r_w2;
    logic [ERR_W-1:0] r_err;

    function automatic logic f_out_of_tol(input logic [CNT_W-1:0] meas,
                                          input logic signed [CNT_W:0] nom);
        logic signed [CNT_W:0] d;
        d = $signed({1'b0, meas}) - nom;
        return (d > TOL_S) || (d < -TOL_S);
    endfunction

    pulse_sync_edge u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (pulse_in),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_lat_w1    = 1'b0;
        w_lat_gap   = 1'b0;
        w_lat_w2    = 1'b0;
        w_done_nxt  = 1'b0;
        w_timeout   = 1'b0;
        w_extra     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise && !r_done) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_P1_HIGH;
                end
            end
            S_P1_HIGH: begin
                if (w_fall) begin
                    w_lat_w1    = 1'b1;
                    w_state_nxt = S_GAP_LOW;
                end else if (r_cnt >= TMO_LIM) begin
                    w_timeout   = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_GAP_LOW: begin
                if (w_rise) begin
                    w_lat_gap   = 1'b1;
                    w_state_nxt = S_P2_HIGH;
                end else if (r_cnt >= TMO_LIM) begin
                    w_timeout   = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_P2_HIGH: begin
                if (w_fall) begin
                    w_lat_w2    = 1'b1;
                    w_state_nxt = S_QUIET;
                end else if (r_cnt >= TMO_LIM) begin
                    w_timeout   = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_QUIET: begin
                if (w_rise) begin
                    w_extra     = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (r_cnt >= QUIET_LIM) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Every edge restarts the interval count at 1; outside a burst it rests at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       r_cnt <= '0;
        else if (w_rise || w_fall)     r_cnt <= CNT_W'(1);
        else if (r_state == S_IDLE)    r_cnt <= '0;
        else if (r_cnt != '1)          r_cnt <= r_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w1m  <= '0;
            r_gapm <= '0;
            r_w2m  <= '0;
        end else if (w_start) begin
            r_w1m  <= '0;
            r_gapm <= '0;
            r_w2m  <= '0;
        end else begin
            if (w_lat_w1)  r_w1m  <= r_cnt;
            if (w_lat_gap) r_gapm <= r_cnt;
            if (w_lat_w2)  r_w2m  <= r_cnt;
        end
    end

    always_comb begin
        w_err              = '0;
        w_err[ERR_W1]      = f_out_of_tol(r_w1m,  NOM_HIGH_S);
        w_err[ERR_GAP]     = f_out_of_tol(r_gapm, NOM_GAP_S);
        w_err[ERR_W2]      = f_out_of_tol(r_w2m,  NOM_HIGH_S);
        w_err[ERR_TIMEOUT] = w_timeout;
        w_err[ERR_EXTRA]   = w_extra;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done <= 1'b0;
            r_pass <= 1'b0;
            r_w1   <= '0;
            r_gap  <= '0;
            r_w2   <= '0;
            r_err  <= '0;
        end else begin
            r_done <= w_done_nxt;
            if (w_done_nxt) begin
                r_w1   <= r_w1m;
                r_gap  <= r_gapm;
                r_w2   <= r_w2m;
                r_err  <= w_err;
                r_pass <= (w_err == '0);
            end
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign pass      = r_pass;
    assign w1        = r_w1;
    assign gap       = r_gap;
    assign w2        = r_w2;
    assign err_flags = r_err;

endmodule
